alu_ctrl_fsm: RTL
=================

// Module: alu_ctrl_fsm
// PURPOSE
//  Multi-cycle control FSM driving the ALU stage and its neighbours: issues ALU_func/ALU_Bin_sel/
//  Immed_ext per instruction, then sequences fetch, decode, execute, memory and write-back.
//  It is the initiator side of the ALU-stage interface; ALU_zero is the only result it reads back.
//  Sits between IR/IMEM, register file, ALU stage and the data-memory handshake.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles Mem_req may stay unacked before abort (only with MEM_TIMEOUT_EN)
// PORTS
//  Clk            in   1   single clock, all state on rising edge
//  Reset_n        in   1   asynchronous, active-low reset
//  Instr          in   32  IR contents, valid from DECODE onward
//  ALU_zero       in   1   ALU_out==0, sampled in EXEC
//  Mem_ack        in   1   data-memory completion, one-cycle pulse
//  IR_LdEn        out  1   load IR from IMEM
//  PC_LdEn        out  1   update PC
//  PC_sel         out  1   0: PC+4, 1: PC+4+(SignExt(Imm)<<2)
//  RF_B_sel       out  1   0: read rt=Instr[15:11], 1: read rd=Instr[20:16]
//  RF_WrEn        out  1   register-file write strobe
//  RF_WrData_sel  out  1   0: ALU_out, 1: MEM_out
//  ALU_Bin_sel    out  1   0: RF_B, 1: extended Immed
//  ALU_func       out  4   0000 add, 0001 sub, 0010 or, 0011 and; R-type passes Instr[3:0]
//  Immed_ext      out  2   00 sign-ext, 01 zero-fill, 10 sign-ext<<2
//  Mem_req        out  1   data-memory request, held until Mem_ack
//  Mem_WrEn       out  1   1 = store (valid with Mem_req)
//  Illegal_op     out  1   one-cycle pulse on unknown opcode
//  Bus_err        out  1   one-cycle pulse on memory timeout (MEM_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - Opcodes Instr[31:26]: 100000 R-type, 111000 li, 110000 addi, 110011 ori, 110010 andi,
//    000000 beq, 000001 bne, 001111 lw, 011111 sw; anything else illegal.
//  - States: IFETCH -> DECODE -> EXEC -> {MEM, WB, IFETCH}; MEM -> {WB, IFETCH}; WB -> IFETCH.
//  - IFETCH: IR_LdEn=1. DECODE: latch opcode/func; drive RF_B_sel=1 for sw/beq/bne.
//    Illegal opcode: Illegal_op=1, PC_LdEn=1, PC_sel=0, next IFETCH.
//  - ALU_func/ALU_Bin_sel/Immed_ext: registered, valid from DECODE through WB (stable operand path).
//    R-type: Instr[3:0], Bin 0. li/addi: add, Bin 1, sign. ori: or, Bin 1, zero. andi: and,
//    Bin 1, zero. lw/sw: add, Bin 1, sign. beq/bne: sub, Bin 0.
//  - EXEC: ALU/imm ops -> WB. lw/sw -> MEM. beq/bne: PC_LdEn=1, PC_sel = beq?ALU_zero:~ALU_zero,
//    next IFETCH.
//  - MEM: Mem_req=1, Mem_WrEn=(sw); stay until Mem_ack. Ack: lw -> WB; sw -> PC_LdEn=1, IFETCH.
//  - WB: RF_WrEn=1, RF_WrData_sel=(lw), PC_LdEn=1, PC_sel=0, next IFETCH.
//  - Strobes (IR_LdEn, PC_LdEn, RF_WrEn, Illegal_op, Bus_err) high exactly one cycle per instruction.
//  - Latency (cycles, IFETCH to next IFETCH): branch 3, ALU/imm 4, sw 4+wait, lw 5+wait.
//  - Mem_ack outside MEM ignored. Mem_ack in the MEM state's first cycle accepted (zero wait).
//  - Reset (any state, incl. MEM wait): state=IFETCH; all outputs 0; ALU_func=0000; Mem_req drops
//    asynchronously. First IR_LdEn is in the first cycle after Reset_n rises.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined: counter clears on MEM entry, increments each unacked MEM cycle; after
//    MEM_TIMEOUT unacked cycles: Mem_req drops, Bus_err pulses, PC_LdEn=1 (skip), RF untouched,
//    next IFETCH. An ack in the same cycle as expiry wins (normal completion).
//  - Not defined: no counter; MEM waits indefinitely; Bus_err is constant 0.
// TESTING
//  - R-type or (op 100000, func 0010) -> ALU_func=0010, Bin_sel=0; RF_WrEn in cycle 4; PC_LdEn same cycle.
//  - addi (110000) -> ALU_func=0000, Bin_sel=1, Immed_ext=00; ori (110011) -> 0010/1/01.
//  - beq, ALU_zero=1 in EXEC -> PC_LdEn=1, PC_sel=1 in cycle 3. bne, ALU_zero=1 -> PC_sel=0.
//  - lw, Mem_ack after 3 wait cycles -> Mem_req 4 cycles, then RF_WrEn=1, RF_WrData_sel=1.
//  - sw, Mem_ack at once -> Mem_WrEn=1 with Mem_req, no RF_WrEn. Reset_n low mid-MEM -> Mem_req=0
//    immediately, IR_LdEn the cycle after release.
//  - Opcode 101010 -> Illegal_op 1-cycle pulse in DECODE. With MEM_TIMEOUT_EN, MEM_TIMEOUT=16, lw,
//    no ack -> Bus_err after 16 MEM cycles, no RF_WrEn.

Source files
------------

// File: rtl/alu_ctrl_fsm_if.sv
// ALU-stage / memory handshake bundle between the control FSM (master) and the datapath (slave).
interface alu_ctrl_fsm_if;
    logic [31:0] Instr;
    logic        ALU_zero;
    logic        Mem_ack;
    logic        IR_LdEn;
    logic        PC_LdEn;
    logic        PC_sel;
    logic        RF_B_sel;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic [1:0]  Immed_ext;
    logic        Mem_req;
    logic        Mem_WrEn;
    logic        Illegal_op;
    logic        Bus_err;

    modport master (
        input  Instr, ALU_zero, Mem_ack,
        output IR_LdEn, PC_LdEn, PC_sel, RF_B_sel, RF_WrEn, RF_WrData_sel,
               ALU_Bin_sel, ALU_func, Immed_ext, Mem_req, Mem_WrEn, Illegal_op, Bus_err
    );

    modport slave (
        output Instr, ALU_zero, Mem_ack,
        input  IR_LdEn, PC_LdEn, PC_sel, RF_B_sel, RF_WrEn, RF_WrData_sel,
               ALU_Bin_sel, ALU_func, Immed_ext, Mem_req, Mem_WrEn, Illegal_op, Bus_err
    );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control FSM: IFETCH -> DECODE -> EXEC -> {MEM, WB} -> IFETCH.
// Optional memory-request timeout is compiled in with `define MEM_TIMEOUT_EN.
module alu_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic            Clk,
    input logic            Reset_n,
    alu_ctrl_fsm_if.master bus
);
    localparam logic [2:0] S_IFETCH = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    typedef enum logic [2:0] {K_ALU, K_BEQ, K_BNE, K_LW, K_SW, K_ILL} kind_e;

    logic [2:0] state, state_nxt;
    kind_e      kind_d, kind_q;
    logic [3:0] func_d, func_q;
    logic       bin_d, bin_q;
    logic [1:0] imm_d, imm_q;
    logic       expired;

    // Only the opcode and R-type func field steer control.
    logic unused_instr;
    assign unused_instr = ^bus.Instr[25:4];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        kind_d = K_ILL;
        func_d = 4'b0000;
        bin_d  = 1'b0;
        imm_d  = 2'b00;
        unique case (bus.Instr[31:26])
            6'b100000: begin kind_d = K_ALU; func_d = bus.Instr[3:0]; end
            6'b111000,
            6'b110000: begin kind_d = K_ALU; bin_d = 1'b1; end
            6'b110011: begin kind_d = K_ALU; func_d = 4'b0010; bin_d = 1'b1; imm_d = 2'b01; end
            6'b110010: begin kind_d = K_ALU; func_d = 4'b0011; bin_d = 1'b1; imm_d = 2'b01; end
            6'b000000: begin kind_d = K_BEQ; func_d = 4'b0001; end
            6'b000001: begin kind_d = K_BNE; func_d = 4'b0001; end
            6'b001111: begin kind_d = K_LW;  bin_d = 1'b1; end
            6'b011111: begin kind_d = K_SW;  bin_d = 1'b1; end
            default:   ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= S_IFETCH;
            kind_q <= K_ILL;
            func_q <= 4'b0000;
            bin_q  <= 1'b0;
            imm_q  <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                kind_q <= kind_d;
                func_q <= func_d;
                bin_q  <= bin_d;
                imm_q  <= imm_d;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt;

    // Counts unacked MEM cycles; expiry is the cycle completing the MEM_TIMEOUT-th wait.
    assign expired = (state == S_MEM) && !bus.Mem_ack
                     && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            wait_cnt <= '0;
        else if (state != S_MEM)
            wait_cnt <= '0;
        else if (!bus.Mem_ack)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = MEM_TIMEOUT;
    assign expired        = 1'b0;
`endif

    always_comb begin
        state_nxt         = state;
        bus.IR_LdEn       = 1'b0;
        bus.PC_LdEn       = 1'b0;
        bus.PC_sel        = 1'b0;
        bus.RF_B_sel      = 1'b0;
        bus.RF_WrEn       = 1'b0;
        bus.RF_WrData_sel = 1'b0;
        bus.Mem_req       = 1'b0;
        bus.Mem_WrEn      = 1'b0;
        bus.Illegal_op    = 1'b0;
        bus.Bus_err       = 1'b0;
        // Operand controls come straight from the decoder in DECODE, then from the latched copy.
        bus.ALU_func    = (state == S_DECODE) ? func_d : func_q;
        bus.ALU_Bin_sel = (state == S_DECODE) ? bin_d  : bin_q;
        bus.Immed_ext   = (state == S_DECODE) ? imm_d  : imm_q;

        case (state)
            S_IFETCH: begin
                // Held off while in reset so the first load lands in the cycle after release.
                bus.IR_LdEn = Reset_n;
                state_nxt   = S_DECODE;
            end
            S_DECODE: begin
                bus.RF_B_sel = (kind_d == K_SW) || (kind_d == K_BEQ) || (kind_d == K_BNE);
                if (kind_d == K_ILL) begin
                    bus.Illegal_op = 1'b1;
                    bus.PC_LdEn    = 1'b1;
                    state_nxt      = S_IFETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (kind_q)
                    K_BEQ, K_BNE: begin
                        bus.PC_LdEn = 1'b1;
                        bus.PC_sel  = (kind_q == K_BEQ) ? bus.ALU_zero : ~bus.ALU_zero;
                        state_nxt   = S_IFETCH;
                    end
                    K_LW, K_SW: state_nxt = S_MEM;
                    default:    state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                bus.Mem_req  = 1'b1;
                bus.Mem_WrEn = (kind_q == K_SW);
                if (bus.Mem_ack) begin
                    if (kind_q == K_SW) begin
                        bus.PC_LdEn = 1'b1;
                        state_nxt   = S_IFETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (expired) begin
                    bus.Bus_err = 1'b1;
                    bus.PC_LdEn = 1'b1;
                    state_nxt   = S_IFETCH;
                end
            end
            S_WB: begin
                bus.RF_WrEn       = 1'b1;
                bus.RF_WrData_sel = (kind_q == K_LW);
                bus.PC_LdEn       = 1'b1;
                state_nxt         = S_IFETCH;
            end
            default: state_nxt = S_IFETCH;
        endcase
    end
endmodule
